code_conv_sched: RTL and testbench
==================================

CODE_CONV_SCHED -- requirements
Module: code_conv_sched

Interface
REQ-001 Parameter: WIDTH, default 4, code word width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: a_valid  input  1  requester A has a conversion request.
REQ-005 Port: a_ready  output  1  requester A request is accepted this cycle.
REQ-006 Port: a_mode  input  1  A conversion direction: 0 = binary->gray, 1 = gray->binary.
REQ-007 Port: a_data  input  WIDTH  A source code word.
REQ-008 Port: b_valid, b_ready, b_mode, b_data  same directions, widths and meanings as the A ports, for requester B.
REQ-009 Port: out_valid  output  1  a result is held in the output register.
REQ-010 Port: out_ready  input  1  downstream consumes the result this cycle.
REQ-011 Port: out_data  output  WIDTH  converted code word.
REQ-012 Port: out_mode  output  1  direction used for out_data.
REQ-013 Port: out_src  output  1  requester served: 0 = A, 1 = B.
REQ-014 Port: done_cnt  output  8  count of results consumed (out_valid && out_ready).

Function
REQ-015 The block SHALL share one converter between A and B, with a single-entry registered output.
REQ-016 State machine SHALL have two states: IDLE (output register empty) and FULL (out_valid=1).
REQ-017 Accept condition SHALL be: state==IDLE, or state==FULL with out_ready=1; on accept, exactly one of a_ready/b_ready SHALL be 1.
REQ-018 Arbitration SHALL be:
- Only one requester valid: that requester is granted.
- Both valid: grant the requester not served by the previous accept (round-robin pointer).
REQ-019 The round-robin pointer SHALL update only on an accept.
REQ-020 a_ready/b_ready SHALL be 0 whenever the accept condition is false or the corresponding valid is 0.
REQ-021 Latency: on an accept at edge N, out_data/out_mode/out_src SHALL be updated at edge N and out_valid SHALL be 1 after edge N.
REQ-022 Transitions:
- IDLE + accept -> FULL.
- FULL + out_ready + accept -> FULL, new result loaded (back-to-back, one result per cycle).
- FULL + out_ready + no request -> IDLE.
- FULL + !out_ready -> FULL, outputs held stable.
REQ-023 Binary->gray conversion SHALL be g[i] = d[i] ^ d[i+1] for i < WIDTH-1, with g[WIDTH-1] = d[WIDTH-1].
REQ-024 Gray->binary conversion SHALL be b[WIDTH-1] = d[WIDTH-1] and b[i] = b[i+1] ^ d[i].
REQ-025 done_cnt SHALL increment by 1 on each consume and wrap 255 -> 0.
REQ-026 Combinational paths: out_ready -> a_ready/b_ready permitted; ready -> valid forbidden.
REQ-027 Requesters SHALL hold valid/mode/data stable until ready; the block does not depend on it for correctness.

Reset
REQ-028 While rst_n=0 the block SHALL hold: state IDLE, out_valid 0, out_data 0, out_mode 0, out_src 0, done_cnt 0, pointer favouring A.
REQ-029 Reset asserted mid-operation SHALL discard any held result; no consume SHALL be counted for it.
REQ-030 a_ready and b_ready SHALL both be 0 while rst_n=0.

Structure
REQ-031 Shared package code_conv_pkg SHALL hold the mode constants (MODE_B2G=0, MODE_G2B=1), the state enum (IDLE, FULL) and the WIDTH default.
REQ-032 Conversion SHALL be in one combinational sub-module, code_conv_core (din, mode -> dout), instantiated once.

Verification
REQ-033 After reset, A valid, mode 0, data 4'b1011, out_ready=1 -> a_ready=1, next cycle out_data=4'b1110, out_src=0, out_mode=0.
REQ-034 B valid, mode 1, data 4'b1110 -> out_data=4'b1011, out_src=1; all 16 codes in both modes round-trip.
REQ-035 A and B continuously valid, out_ready=1 -> grants alternate A,B,A,B (A first after reset); one result per cycle; done_cnt increments every cycle.
REQ-036 out_ready=0 for 5 cycles while FULL -> outputs stable, a_ready=b_ready=0; out_ready=1 -> consume and accept of the next request in the same cycle.
REQ-037 256 consumes -> done_cnt wraps to 0; rst_n low while FULL -> out_valid=0 immediately, done_cnt=0.

Source files
------------

// File: rtl/code_conv_pkg.sv
// Shared definitions for the code converter scheduler.
// Holds the conversion-direction constants, the output-register state
// encoding and the default code word width.
package code_conv_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic MODE_B2G = 1'b0;   // binary -> gray
    localparam logic MODE_G2B = 1'b1;   // gray -> binary

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/code_conv_core.sv
// Combinational binary<->gray converter.
// Ports:
//   din   source code word
//   mode  MODE_B2G or MODE_G2B
//   dout  converted code word
module code_conv_core
    import code_conv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;

    always_comb begin
        gray = din ^ (din >> 1);
        // Gray decode is a running XOR from the MSB downwards.
        bin = din;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ din[i];
        end
        dout = (mode == MODE_G2B) ? bin : gray;
    end

endmodule

// File: rtl/code_conv_sched.sv
// Two-requester scheduler sharing one code converter, with a single-entry
// registered output and a consumed-result counter.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   a_valid/a_ready/a_mode/a_data requester A handshake and request
//   b_valid/b_ready/b_mode/b_data requester B handshake and request
//   out_valid/out_ready           output register handshake
//   out_data/out_mode/out_src     converted word, direction, requester served
//   done_cnt                      results consumed, wraps at 255
//
// state | meaning
// IDLE  | output register empty
// FULL  | output register holds a result (out_valid=1)
module code_conv_sched
    import code_conv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_mode,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_mode,
    input  logic [WIDTH-1:0] b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_src,
    output logic [7:0]       done_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;      // 1 = favour B when both request
    logic             grant_b;
    logic             accept;
    logic             consume;
    logic             sel_mode;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] conv_data;

    assign out_valid = (state == FULL);
    assign consume   = out_valid && out_ready;
    assign sel_mode  = grant_b ? b_mode : a_mode;
    assign sel_data  = grant_b ? b_data : a_data;

    code_conv_core #(.WIDTH(WIDTH)) u_core (
        .din  (sel_data),
        .mode (sel_mode),
        .dout (conv_data)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        grant_b   = b_valid && (!a_valid || rr_ptr);
        // rst_n gating keeps both readies low throughout reset.
        if (rst_n && ((state == IDLE) || out_ready) && (a_valid || b_valid)) begin
            accept  = 1'b1;
            a_ready = !grant_b;
            b_ready = grant_b;
        end
        case (state)
            IDLE:    if (accept) state_nxt = FULL;
            FULL:    if (out_ready && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            out_data <= '0;
            out_mode <= 1'b0;
            out_src  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rr_ptr   <= !grant_b;
                out_data <= conv_data;
                out_mode <= sel_mode;
                out_src  <= grant_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= 8'd0;
        end else if (consume) begin
            done_cnt <= done_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_code_conv_sched.sv
// Self-checking bench for code_conv_sched: a cycle model of the scheduler
// predicts readies, and a queue of expected results is compared against the
// output register while it is full.
module tb_code_conv_sched;

    localparam int W = 4;

    typedef struct packed {
        logic         src;
        logic         mode;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_valid, a_mode, b_valid, b_mode;
    logic [W-1:0] a_data, b_data;
    logic         a_ready, b_ready;
    logic         out_valid, out_ready, out_mode, out_src;
    logic [W-1:0] out_data;
    logic [7:0]   done_cnt;

    int   n_total = 0;
    int   n_pass  = 0;

    exp_t exp_q[$];
    logic m_full;
    logic m_rr;
    logic [7:0] m_done;

    always #5 clk = ~clk;

    code_conv_sched #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_mode    (a_mode),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_mode    (b_mode),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_src   (out_src),
        .done_cnt  (done_cnt)
    );

    function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] d);
        logic [W-1:0] g;
        g[W-1] = d[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = d[i] ^ d[i+1];
        return g;
    endfunction

    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] d);
        logic [W-1:0] b;
        // bit i is the parity of gray bits i..W-1
        for (int i = 0; i < W; i++) begin
            b[i] = 1'b0;
            for (int j = i; j < W; j++) b[i] = b[i] ^ d[j];
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic av, input logic am, input logic [W-1:0] ad,
                         input logic bv, input logic bm, input logic [W-1:0] bd,
                         input logic ordy);
        a_valid = av; a_mode = am; a_data = ad;
        b_valid = bv; b_mode = bm; b_data = bd;
        out_ready = ordy;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_rr   = 1'b0;
        m_done = 8'd0;
        exp_q.delete();
    endtask

    // Called just after a falling edge with inputs already driven; checks the
    // cycle, advances the model and returns just after the next falling edge.
    task automatic step();
        logic acc, gb;
        exp_t e, f;
        #1;
        acc = (!m_full || out_ready) && (a_valid || b_valid);
        gb  = b_valid && (!a_valid || m_rr);
        chk("a_ready", a_ready, acc && !gb);
        chk("b_ready", b_ready, acc && gb);
        chk("out_valid", out_valid, m_full);
        chk("done_cnt", done_cnt, m_done);
        if (m_full) begin
            chk("sb_size", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                f = exp_q[0];
                chk("out_data", out_data, f.data);
                chk("out_mode", out_mode, f.mode);
                chk("out_src", out_src, f.src);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (out_ready) m_done = m_done + 8'd1;
        end
        if (acc) begin
            e.src  = gb;
            e.mode = gb ? b_mode : a_mode;
            e.data = gb ? (b_mode ? ref_g2b(b_data) : ref_b2g(b_data))
                        : (a_mode ? ref_g2b(a_data) : ref_b2g(a_data));
            exp_q.push_back(e);
            m_rr = !gb;
        end
        m_full = acc || (m_full && !out_ready);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 4'b0011, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // A, binary->gray of 1011
        drive(1'b1, 1'b0, 4'b1011, 1'b0, 1'b0, 4'b0000, 1'b1);
        #1 chk("first_a_ready", a_ready, 1);
        step();
        chk("first_data", out_data, 4'b1110);
        chk("first_src", out_src, 0);
        chk("first_mode", out_mode, 0);

        // B, gray->binary of 1110 (back-to-back with the consume of A)
        drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b1110, 1'b1);
        step();
        chk("b_data", out_data, 4'b1011);
        chk("b_src", out_src, 1);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        step();

        // Round trip: encode on A, decode the gray code on B, expect d back
        for (int d = 0; d < 16; d++) begin
            drive(1'b1, 1'b0, 4'(d), 1'b0, 1'b0, 4'b0000, 1'b1);
            step();
            drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, ref_b2g(4'(d)), 1'b1);
            step();
            chk("round_trip", out_data, 32'(d));
        end
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        step();

        // Both continuously valid: A first after reset, then alternate
        do_reset();
        drive(1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 4'b1001, 1'b1);
        for (int i = 0; i < 8; i++) begin
            #1 chk("alt_grant_b", b_ready, 32'(i % 2));
            step();
        end

        // Stall for 5 cycles while FULL, then consume and accept together
        drive(1'b1, 1'b0, 4'b0111, 1'b1, 1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) step();
        drive(1'b1, 1'b0, 4'b0111, 1'b1, 1'b1, 4'b0100, 1'b1);
        #1 chk("stall_release_acc", a_ready || b_ready, 1);
        step();
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        step();

        // 256 consumes wrap done_cnt to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, i[0], 4'(i), 1'b0, 1'b0, 4'b0000, 1'b1);
            step();
        end
        chk("cnt_255", done_cnt, 255);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        step();
        chk("cnt_wrap", done_cnt, 0);

        // Reset while FULL discards the result
        drive(1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b0000, 1'b1);
        step();
        drive(1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, 4'b0000, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_done_cnt", done_cnt, 0);
        chk("midrst_a_ready", a_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
